// File: rtl/rdata_router.sv
// Read-return multiplexer: tracks accepted reads through a short return
// pipeline so each slave can answer after its own fixed latency.
module rdata_router #(
  parameter int                   NUM_SLV  = 4,
  parameter int                   DW       = 32,
  parameter int                   MAX_LAT  = 3,
  parameter logic [2*NUM_SLV-1:0] LAT_VEC  = {NUM_SLV{2'd1}},
  parameter logic [DW-1:0]        DEF_DATA = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [NUM_SLV-1:0]    cs_n,
  input  logic [NUM_SLV*DW-1:0] read_data_slv,
  output logic                  stall,
  output logic [DW-1:0]         read_data,
  output logic                  read_valid,
  output logic                  rd_err,
  output logic                  err_multi,
  output logic [7:0]            err_cnt
);
  localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  logic [1:0]    lat_tab  [NUM_SLV];
  logic [DW-1:0] slv_data [NUM_SLV];

  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
      assign lat_tab[gi]  = LAT_VEC[2*gi +: 2];
      assign slv_data[gi] = read_data_slv[DW*gi +: DW];
      if (LAT_VEC[2*gi +: 2] == 2'd0 || int'(LAT_VEC[2*gi +: 2]) > MAX_LAT) begin : g_bad_lat
        $error("rdata_router: LAT_VEC entry %0d out of range 1..MAX_LAT", gi);
      end
    end
    if (MAX_LAT < 1) begin : g_bad_max
      $error("rdata_router: MAX_LAT must be at least 1");
    end
  endgenerate

  // Return pipeline: entry k returns k cycles from now (entry 0 is live).
  logic [MAX_LAT-1:0] vld_reg, vld_next;
  logic [MAX_LAT-1:0] err_reg, err_next;
  logic [IW-1:0]      idx_reg  [MAX_LAT];
  logic [IW-1:0]      idx_next [MAX_LAT];

  logic       err_multi_reg, err_multi_next;
  logic [7:0] err_cnt_reg, err_cnt_next;

  logic [NUM_SLV-1:0] low;
  logic [IW-1:0]      sel;
  logic               none;
  logic               multi;
  logic [31:0]        lat;
  logic               target_busy;
  logic               accept;

  assign low   = ~cs_n;
  assign none  = (low == '0);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(low & (low - NUM_SLV'(1)));

  always_comb begin
    sel = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (low[i]) sel = IW'(i);
    end
  end

  assign lat = none ? 32'd1 : 32'(lat_tab[sel]);

  // A request of latency MAX_LAT lands beyond every occupied entry.
  always_comb begin
    target_busy = 1'b0;
    for (int k = 1; k < MAX_LAT; k++) begin
      if (lat == 32'(k)) target_busy = vld_reg[k];
    end
  end

  assign stall  = ~rst & rd_req & target_busy;
  assign accept = ~rst & rd_req & ~target_busy;

  always_comb begin
    vld_next = '0;
    err_next = '0;
    for (int k = 0; k < MAX_LAT; k++) idx_next[k] = '0;
    for (int k = 0; k < MAX_LAT - 1; k++) begin
      vld_next[k] = vld_reg[k+1];
      err_next[k] = err_reg[k+1];
      idx_next[k] = idx_reg[k+1];
    end
    if (accept) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        if (lat == 32'(k + 1)) begin
          vld_next[k] = 1'b1;
          err_next[k] = none;
          idx_next[k] = sel;
        end
      end
    end
  end

  always_comb begin
    err_multi_next = accept & multi;
    err_cnt_next   = err_cnt_reg;
    if (accept && (none || multi) && (err_cnt_reg != 8'hFF)) begin
      err_cnt_next = err_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg       <= '0;
      err_reg       <= '0;
      for (int k = 0; k < MAX_LAT; k++) idx_reg[k] <= '0;
      err_multi_reg <= 1'b0;
      err_cnt_reg   <= 8'd0;
    end else begin
      vld_reg       <= vld_next;
      err_reg       <= err_next;
      for (int k = 0; k < MAX_LAT; k++) idx_reg[k] <= idx_next[k];
      err_multi_reg <= err_multi_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign read_valid = ~rst & vld_reg[0];
  assign rd_err     = read_valid & err_reg[0];
  assign err_multi  = ~rst & err_multi_reg;
  assign err_cnt    = rst ? 8'd0 : err_cnt_reg;

  always_comb begin
    read_data = '0;
    if (read_valid) read_data = err_reg[0] ? DEF_DATA : slv_data[idx_reg[0]];
  end

endmodule
